// File: rtl/load_store_unit_if.sv
// Core/Data_Memory bundle for the load/store unit. The master side is the
// core plus memory environment; the slave side is the LSU itself.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] Addr;
  logic [31:0]           Store_Data;
  logic [31:0]           Load_Data;
  logic                  stall;
  logic                  misalign;
  logic                  dm_MemWrite;
  logic [ADDR_WIDTH-1:0] dm_Mem_Addr;
  logic [31:0]           dm_Write_Data;
  logic [31:0]           dm_Read_Data;

  modport master (
    output MemRead, MemWrite, funct3, Addr, Store_Data, dm_Read_Data,
    input  Load_Data, stall, misalign, dm_MemWrite, dm_Mem_Addr, dm_Write_Data
  );

  modport slave (
    input  MemRead, MemWrite, funct3, Addr, Store_Data, dm_Read_Data,
    output Load_Data, stall, misalign, dm_MemWrite, dm_Mem_Addr, dm_Write_Data
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: sub-word load extraction and SB/SH read-modify-write
// over a word-only Data_Memory. Define LSU_PERF_CNT_EN for performance counters.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  load_store_unit_if.slave     bus
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] load_cnt,
  output logic [CNT_WIDTH-1:0] store_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] misalign_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01
  } state_t;

  state_t                state, state_nxt;
  logic [31:0]           merge_reg, merge_nxt;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_nxt;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  aligned;

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: return 1'b1;
      3'b001, 3'b101: return ~a[0];
      3'b010:         return (a == 2'b00);
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] w,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  a);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Insert the store byte/halfword into the addressed lane of the current word.
  function automatic logic [31:0] merge_store(input logic [31:0] w,
                                              input logic [31:0] d,
                                              input logic        half,
                                              input logic [1:0]  a);
    logic [31:0] m;
    m = w;
    if (half) begin
      if (a[1]) m[31:16] = d[15:0];
      else      m[15:0]  = d[15:0];
    end else begin
      case (a)
        2'd0: m[7:0]   = d[7:0];
        2'd1: m[15:8]  = d[7:0];
        2'd2: m[23:16] = d[7:0];
        default: m[31:24] = d[7:0];
      endcase
    end
    return m;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign word_addr = {bus.Addr[ADDR_WIDTH-1:2], 2'b00};
  assign aligned   = is_aligned(bus.funct3, bus.Addr[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      merge_reg <= '0;
      addr_reg  <= '0;
    end else begin
      state     <= state_nxt;
      merge_reg <= merge_nxt;
      addr_reg  <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    merge_nxt         = merge_reg;
    addr_nxt          = addr_reg;
    bus.stall         = 1'b0;
    bus.misalign      = 1'b0;
    bus.dm_MemWrite   = 1'b0;
    bus.Load_Data     = '0;
    bus.dm_Write_Data = '0;
    bus.dm_Mem_Addr   = word_addr;
    case (state)
      IDLE: begin
        if (bus.MemRead || bus.MemWrite) begin
          if (!aligned) begin
            bus.misalign = 1'b1;
          end else if (bus.MemWrite) begin
            if (bus.funct3[1:0] == 2'b10) begin
              bus.dm_MemWrite   = 1'b1;
              bus.dm_Write_Data = bus.Store_Data;
            end else begin
              bus.stall = 1'b1;
              merge_nxt = merge_store(bus.dm_Read_Data, bus.Store_Data,
                                      bus.funct3[0], bus.Addr[1:0]);
              addr_nxt  = word_addr;
              state_nxt = WRITE;
            end
          end else begin
            bus.Load_Data = extend_load(bus.dm_Read_Data, bus.funct3, bus.Addr[1:0]);
          end
        end
      end
      WRITE: begin
        bus.dm_MemWrite   = 1'b1;
        bus.dm_Mem_Addr   = addr_reg;
        bus.dm_Write_Data = merge_reg;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset must kill a pending write at once, not at the next edge.
    if (reset) begin
      bus.stall         = 1'b0;
      bus.misalign      = 1'b0;
      bus.dm_MemWrite   = 1'b0;
      bus.Load_Data     = '0;
      bus.dm_Write_Data = '0;
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic load_done;

  assign load_done = (state == IDLE) && bus.MemRead && !bus.MemWrite && aligned && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt     <= '0;
      store_cnt    <= '0;
      stall_cnt    <= '0;
      misalign_cnt <= '0;
    end else begin
      if (load_done)       load_cnt     <= sat_inc(load_cnt);
      if (bus.dm_MemWrite) store_cnt    <= sat_inc(store_cnt);
      if (bus.stall)       stall_cnt    <= sat_inc(stall_cnt);
      if (bus.misalign)    misalign_cnt <= sat_inc(misalign_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] mem [0:15];

  load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

`ifdef LSU_PERF_CNT_EN
  logic [15:0] load_cnt, store_cnt, stall_cnt, misalign_cnt;
`endif

  load_store_unit #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef LSU_PERF_CNT_EN
    ,
    .load_cnt     (load_cnt),
    .store_cnt    (store_cnt),
    .stall_cnt    (stall_cnt),
    .misalign_cnt (misalign_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.dm_Read_Data = mem[bus.dm_Mem_Addr[5:2]];

  always @(posedge clk) begin
    if (bus.dm_MemWrite) mem[bus.dm_Mem_Addr[5:2]] <= bus.dm_Write_Data;
  end

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    bus.MemRead    = rd;
    bus.MemWrite   = wr;
    bus.funct3     = f3;
    bus.Addr       = a;
    bus.Store_Data = d;
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b1, 3'b010, 32'h4, 32'hDEADBEEF);
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
    checks++; if (bus.dm_MemWrite !== 1'b0) begin errors++; $display("FAIL reset_memwrite got %b exp 0", bus.dm_MemWrite); end
    checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", bus.misalign); end
    checks++; if (bus.Load_Data !== 32'h0) begin errors++; $display("FAIL reset_load_data got %h exp 0", bus.Load_Data); end
    checks++; if (bus.dm_Write_Data !== 32'h0) begin errors++; $display("FAIL reset_write_data got %h exp 0", bus.dm_Write_Data); end
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    reset = 1'b0;
  endtask

  task automatic test_loads;
    logic [2:0]  f3s  [4];
    logic [31:0] adrs [4];
    logic [31:0] exps [4];
    f3s = '{3'b000, 3'b100, 3'b001, 3'b101};
    adrs = '{32'h3, 32'h3, 32'h2, 32'h0};
    exps = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFFAABB, 32'h0000CCDD};
    @(negedge clk);
    mem[0] = 32'hAABBCCDD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, f3s[i], adrs[i], 32'h0);
      #1;
      checks++; if (bus.Load_Data !== exps[i]) begin errors++; $display("FAIL load_%0d got %h exp %h", i, bus.Load_Data, exps[i]); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL load_stall_%0d got %b exp 0", i, bus.stall); end
    end
  endtask

  task automatic test_store_word;
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b010, 32'h4, 32'h11223344);
    #1;
    checks++; if (bus.dm_MemWrite !== 1'b1) begin errors++; $display("FAIL sw_memwrite got %b exp 1", bus.dm_MemWrite); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sw_stall got %b exp 0", bus.stall); end
    checks++; if (bus.dm_Write_Data !== 32'h11223344) begin errors++; $display("FAIL sw_wdata got %h exp 11223344", bus.dm_Write_Data); end
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
    #1;
    checks++; if (bus.dm_MemWrite !== 1'b0) begin errors++; $display("FAIL sw_one_cycle got %b exp 0", bus.dm_MemWrite); end
    checks++; if (bus.Load_Data !== 32'h11223344) begin errors++; $display("FAIL lw_after_sw got %h exp 11223344", bus.Load_Data); end
  endtask

  task automatic test_store_byte;
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    mem[0] = 32'hAABBCCDD;
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b000, 32'h1, 32'h00000055);
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sb_stall got %b exp 1", bus.stall); end
    checks++; if (bus.dm_MemWrite !== 1'b0) begin errors++; $display("FAIL sb_no_early_write got %b exp 0", bus.dm_MemWrite); end
    @(negedge clk);
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sb_stall_write got %b exp 0", bus.stall); end
    checks++; if (bus.dm_MemWrite !== 1'b1) begin errors++; $display("FAIL sb_write got %b exp 1", bus.dm_MemWrite); end
    checks++; if (bus.dm_Write_Data !== 32'hAABB55DD) begin errors++; $display("FAIL sb_wdata got %h exp aabb55dd", bus.dm_Write_Data); end
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    #1;
    checks++; if (bus.Load_Data !== 32'hAABB55DD) begin errors++; $display("FAIL lw_after_sb got %h exp aabb55dd", bus.Load_Data); end
  endtask

  task automatic test_store_half;
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    mem[0] = 32'hAABBCCDD;
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b001, 32'h2, 32'h00001234);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checks++; if (mem[0] !== 32'h1234CCDD) begin errors++; $display("FAIL sh_mem got %h exp 1234ccdd", mem[0]); end
  endtask

  task automatic test_misalign;
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b001, 32'h1, 32'h0000FFFF);
    #1;
    checks++; if (bus.misalign !== 1'b1) begin errors++; $display("FAIL sh_mis_flag got %b exp 1", bus.misalign); end
    checks++; if (bus.dm_MemWrite !== 1'b0) begin errors++; $display("FAIL sh_mis_write got %b exp 0", bus.dm_MemWrite); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sh_mis_stall got %b exp 0", bus.stall); end
    @(negedge clk);
    checks++; if (mem[0] !== 32'h1234CCDD) begin errors++; $display("FAIL sh_mis_mem got %h exp 1234ccdd", mem[0]); end
    drive(1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
    #1;
    checks++; if (bus.misalign !== 1'b1) begin errors++; $display("FAIL lw_mis_flag got %b exp 1", bus.misalign); end
    checks++; if (bus.Load_Data !== 32'h0) begin errors++; $display("FAIL lw_mis_data got %h exp 0", bus.Load_Data); end
  endtask

  task automatic test_priority;
    @(negedge clk);
    drive(1'b1, 1'b1, 3'b010, 32'h8, 32'hCAFEF00D);
    #1;
    checks++; if (bus.Load_Data !== 32'h0) begin errors++; $display("FAIL prio_load got %h exp 0", bus.Load_Data); end
    checks++; if (bus.dm_MemWrite !== 1'b1) begin errors++; $display("FAIL prio_write got %b exp 1", bus.dm_MemWrite); end
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checks++; if (mem[2] !== 32'hCAFEF00D) begin errors++; $display("FAIL prio_mem got %h exp cafef00d", mem[2]); end
  endtask

  task automatic test_wrap;
    mem[15] = 32'h01020304;
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b000, 32'hFFFFFFFF, 32'h000000EE);
    #1;
    checks++; if (bus.dm_Mem_Addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", bus.dm_Mem_Addr); end
    @(negedge clk);
    #1;
    checks++; if (bus.dm_Mem_Addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_waddr got %h exp fffffffc", bus.dm_Mem_Addr); end
    checks++; if (bus.dm_Write_Data !== 32'hEE020304) begin errors++; $display("FAIL wrap_wdata got %h exp ee020304", bus.dm_Write_Data); end
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back;
    mem[3] = 32'h0;
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b000, 32'hC, 32'h00000011);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b000, 32'hE, 32'h00000022);
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL b2b_stall got %b exp 1", bus.stall); end
    checks++; if (mem[3] !== 32'h00000011) begin errors++; $display("FAIL b2b_first got %h exp 00000011", mem[3]); end
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checks++; if (mem[3] !== 32'h00220011) begin errors++; $display("FAIL b2b_second got %h exp 00220011", mem[3]); end
  endtask

  task automatic test_reset_write;
    mem[0] = 32'hAABBCCDD;
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b000, 32'h0, 32'h00000077);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (bus.dm_MemWrite !== 1'b0) begin errors++; $display("FAIL rstw_memwrite got %b exp 0", bus.dm_MemWrite); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rstw_stall got %b exp 0", bus.stall); end
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    checks++; if (mem[0] !== 32'hAABBCCDD) begin errors++; $display("FAIL rstw_mem got %h exp aabbccdd", mem[0]); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rstw_stall_after got %b exp 0", bus.stall); end
`ifdef LSU_PERF_CNT_EN
    checks++; if ({load_cnt, store_cnt, stall_cnt, misalign_cnt} !== 64'h0) begin errors++; $display("FAIL rstw_counters got %h exp 0", {load_cnt, store_cnt, stall_cnt, misalign_cnt}); end
`endif
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    #1;
    checks++; if (bus.Load_Data !== 32'hAABBCCDD) begin errors++; $display("FAIL rstw_idle_load got %h exp aabbccdd", bus.Load_Data); end
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    test_reset;
    test_loads;
    test_store_word;
    test_store_byte;
    test_store_half;
    test_misalign;
    test_priority;
    test_wrap;
    test_back_to_back;
    test_reset_write;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
